// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request/response with wait states.
// Define DMEM_MISALIGN_CHECK_EN to reject misaligned half/word accesses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          cur_wr;
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic [2:0]    cur_f3;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   ld_data;
  logic          legal;
  logic          misal;
  logic          err;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic          go_resp;
  logic          we;
  logic          unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];

  // Operand mux: the accept cycle uses live inputs (WAIT_CYCLES=0 path).
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_wr    = req_write;
      cur_addr  = req_addr[AW+1:0];
      cur_wdata = req_wdata;
      cur_f3    = req_funct3;
    end else begin
      cur_wr    = write_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_f3    = f3_q;
    end
  end

  always_comb begin
    idx     = cur_addr[AW+1:2];
    rd_word = mem_q[idx];
    rd_byte = rd_word[8*cur_addr[1:0] +: 8];
    rd_half = cur_addr[1] ? rd_word[31:16]
                          : rd_word[15:0];
    ld_data = '0;
    unique case (cur_f3)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'd0, rd_byte};
      3'b101:  ld_data = {16'd0, rd_half};
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    if (cur_wr)
      legal = (cur_f3 == 3'b000) || (cur_f3 == 3'b001)
           || (cur_f3 == 3'b010);
    else
      legal = (cur_f3 != 3'b011) && (cur_f3 != 3'b110)
           && (cur_f3 != 3'b111);
`ifdef DMEM_MISALIGN_CHECK_EN
    misal = ((cur_f3[1:0] == 2'b01) && cur_addr[0])
         || ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
`else
    misal = 1'b0;
`endif
    err = !legal || misal;
  end

  always_comb begin
    be    = 4'b0000;
    wlane = cur_wdata;
    unique case (cur_f3[1:0])
      2'b00: begin
        be    = 4'b0001 << cur_addr[1:0];
        wlane = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{cur_wdata[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    go_resp     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          addr_d      = req_addr[AW+1:0];
          wdata_d     = req_wdata;
          f3_d        = req_funct3;
          req_ready_d = 1'b0;
          if (WAIT_CYCLES == 0) begin
            go_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) go_resp = 1'b1;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (go_resp) begin
      state_d     = S_RESP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = err;
      rsp_rdata_d = (!err && !cur_wr) ? ld_data : 32'd0;
    end
    we = go_resp && cur_wr && !err && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is deliberately outside reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i])
        mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=256, WAIT_CYCLES=2).
// Expected values are hand-computed; misaligned-word case follows the macro.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_vec = 0;
  int n_bad = 0;

  dmem_responder #(
    .DEPTH_WORDS(256),
    .WAIT_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_funct3(req_funct3),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic xact(input string tag,
                      input logic wr,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [2:0] f3,
                      input int stall,
                      input logic [31:0] exp_d,
                      input logic exp_e);
    int  lat;
    bit  got;
    chk({tag, " rdy"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = a;
    req_wdata  = wd;
    req_funct3 = f3;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'hFFFF_FFFC;
    req_wdata  = 32'h5A5A_5A5A;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) got = 1'b1;
    end
    chk({tag, " lat"}, lat, 32'd3);
    chk({tag, " data"}, rsp_rdata, exp_d);
    chk({tag, " err"}, {31'd0, rsp_err}, {31'd0, exp_e});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, " hold v"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, " hold d"}, rsp_rdata, exp_d);
      chk({tag, " hold r"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    chk("rst err", {31'd0, rsp_err}, 32'd0);
    chk("rst ready", {31'd0, req_ready}, 32'd1);

    xact("sw10", 1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 32'h0, 0);
    xact("lw10", 0, 32'h10, 32'h0, 3'b010, 0, 32'hDEADBEEF, 0);
    xact("sb11", 1, 32'h11, 32'h80, 3'b000, 0, 32'h0, 0);
    xact("lb11", 0, 32'h11, 32'h0, 3'b000, 0, 32'hFFFFFF80, 0);
    xact("lbu11", 0, 32'h11, 32'h0, 3'b100, 0, 32'h00000080, 0);
    xact("lw10b", 0, 32'h10, 32'h0, 3'b010, 0, 32'hDEAD80EF, 0);
    xact("stall", 0, 32'h10, 32'h0, 3'b010, 5, 32'hDEAD80EF, 0);

    xact("sw400", 1, 32'h400, 32'h12345678, 3'b010, 0, 32'h0, 0);
    xact("lw0", 0, 32'h0, 32'h0, 3'b010, 0, 32'h12345678, 0);

    xact("ld011", 0, 32'h0, 32'h0, 3'b011, 0, 32'h0, 1);
    xact("st011", 1, 32'h0, 32'hFFFFFFFF, 3'b011, 0, 32'h0, 1);
    xact("lw0b", 0, 32'h0, 32'h0, 3'b010, 0, 32'h12345678, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
    xact("lw2", 0, 32'h2, 32'h0, 3'b010, 0, 32'h0, 1);
`else
    xact("lw2", 0, 32'h2, 32'h0, 3'b010, 0, 32'h12345678, 0);
`endif

    xact("sh2", 1, 32'h2, 32'h0000F00D, 3'b001, 0, 32'h0, 0);
    xact("lh2", 0, 32'h2, 32'h0, 3'b001, 0, 32'hFFFFF00D, 0);
    xact("lhu2", 0, 32'h2, 32'h0, 3'b101, 0, 32'h0000F00D, 0);
    xact("lh0", 0, 32'h0, 32'h0, 3'b001, 0, 32'h00005678, 0);

    // Store abandoned by reset while still waiting.
    chk("wrst rdy", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 32'h10;
    req_wdata  = 32'hCAFEF00D;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    @(negedge clk);
    chk("wrst wait", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("wrst valid", {31'd0, rsp_valid}, 32'd0);
    chk("wrst idle", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("wrst still", {31'd0, rsp_valid}, 32'd0);
    xact("lwold", 0, 32'h10, 32'h0, 3'b010, 0, 32'hDEAD80EF, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: storage depth in 32-bit words, power of two, 4..4096.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states between request accept and response, 0..15.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port req_funct3  input  3  RV32I load/store funct3.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator accepts the response.
REQ-013 SHALL have port rsp_rdata  output  32  load result, already extended; 0 for stores.
REQ-014 SHALL have port rsp_err  output  1  access rejected.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE with one outstanding request maximum.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge with req_valid&req_ready, latching write, addr, wdata and funct3.
REQ-017 SHALL go from IDLE to WAIT on accept when WAIT_CYCLES>0 (counter loaded to WAIT_CYCLES), otherwise directly to RESP.
REQ-018 SHALL decrement the counter each WAIT cycle and enter RESP on the edge at which the counter reaches 1.
REQ-019 SHALL assert rsp_valid first in the cycle 1+WAIT_CYCLES after the accept edge, with rsp_rdata and rsp_err stable while rsp_valid=1.
REQ-020 SHALL hold RESP until rsp_valid&rsp_ready, then return to IDLE; no request is accepted in that same cycle (minimum 2+WAIT_CYCLES cycles per transaction).
REQ-021 SHALL form word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap-around).
REQ-022 SHALL perform store writes once, on the edge entering RESP, using byte enables: SB (000) lane addr[1:0]; SH (001) lanes {addr[1],0},{addr[1],1}; SW (010) all four lanes.
REQ-023 SHALL compute load data from the addressed word in the cycle before RESP: LB (000) / LH (001) sign-extended, LW (010), LBU (100) / LHU (101) zero-extended; byte lane addr[1:0], half lane addr[1].
REQ-024 SHALL treat load funct3 011/110/111 and store funct3 other than 000/001/010 as illegal: rsp_err=1, rsp_rdata=0, no write.
REQ-025 SHALL return rsp_rdata=0 and rsp_err=0 for legal stores.
REQ-026 SHALL make a load following a store to the same word observe the stored data.
REQ-027 SHALL ignore req_valid and all req_* inputs outside IDLE.

Reset
REQ-028 SHALL, on an edge with rst=1, enter IDLE, clear the counter and set rsp_valid=0, rsp_rdata=0 and rsp_err=0; req_ready is 1 in the first cycle after reset.
REQ-029 SHALL, on reset mid-transaction, abandon the transaction; a store not yet committed (still in WAIT) SHALL NOT be written.
REQ-030 SHALL leave storage contents unchanged by reset.

Configuration
REQ-031 SHALL honour macro DMEM_MISALIGN_CHECK_EN: when defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 returns rsp_err=1 and rsp_rdata=0, with no write.
REQ-032 SHALL, without DMEM_MISALIGN_CHECK_EN, ignore misaligned low bits (half uses addr[1], word uses none) and return rsp_err=0.

Verification
REQ-033 SHALL cover: WAIT_CYCLES=2, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata 0xDEADBEEF, rsp_valid exactly 3 cycles after each accept.
REQ-034 SHALL cover: after REQ-033, SB addr 0x11 data 0x80, then LB 0x11 -> 0xFFFFFF80, LBU 0x11 -> 0x00000080, LW 0x10 -> 0xDEAD80EF.
REQ-035 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0 throughout.
REQ-036 SHALL cover: DEPTH_WORDS=256, SW addr 0x400 data 0x12345678, then LW 0x0 -> 0x12345678 (wrap).
REQ-037 SHALL cover: load funct3=011 -> rsp_err=1, rsp_rdata=0; with DMEM_MISALIGN_CHECK_EN, LW addr 0x2 -> rsp_err=1; without it -> rsp_err=0 and data of word 0.
REQ-038 SHALL cover: SW accepted, rst pulsed during WAIT -> IDLE next cycle, rsp_valid=0, and a subsequent LW to that address returns the old data.
